cc_banks_rw0_initiator: RTL and testbench

//  Request-side driver for a single-port RW0 SRAM bank (cc_banks_* wrappers: RW0_addr/en/wmode/wdata/rdata).

---
 rtl/cc_banks_rw0_initiator.sv | 131 +++++++++++++
 tb/tb_cc_banks_rw0_initiator.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_banks_rw0_initiator.sv
// Request-side driver for a single-port RW0 SRAM bank.
// Turns a valid/ready request stream into RW0 strobes and returns read data
// in request order on a valid/ready response stream. The fixed 1-cycle RW0
// read latency is absorbed by an in-flight flag plus a small response FIFO.
// A credit check keeps reads from overrunning that FIFO, so read data is
// never dropped under backpressure. Writes bypass the credit check because
// they produce no response.
module cc_banks_rw0_initiator #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 64,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(RSP_DEPTH - 1);

    // State: one read in flight toward the bank, plus the buffered responses.
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [DATA_W-1:0] mem_q [RSP_DEPTH];

    logic             fifo_empty;
    logic             fire;
    logic             pop;
    logic             fifo_pop;
    logic             push;
    logic [CNT_W:0]   used;
    logic [CNT_W:0]   limit;
    logic             has_credit;

    // Response selection, credit computation and the bank-side strobes.
    always_comb begin
        // NOTE: every output of this block gets a default on every path, so no latch is inferred.
        fifo_empty = (count_q == '0);

        // With an empty FIFO the bank output is presented directly (bypass).
        rsp_valid  = !reset && (inflight_q || !fifo_empty);
        rsp_rdata  = fifo_empty ? RW0_rdata : mem_q[rd_ptr_q];
        pop        = rsp_valid && rsp_ready;
        fifo_pop   = pop && !fifo_empty;

        // Arriving bank data is stored unless the bypass hands it straight to the consumer.
        push       = !reset && inflight_q && !(fifo_empty && rsp_ready);

        // free = RSP_DEPTH - count - inflight + pop; a read may issue when free > 0.
        used       = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        limit      = DEPTH_C + (CNT_W + 1)'(pop);
        has_credit = (used < limit);

        req_ready  = !reset && (req_write || has_credit);
        fire       = req_valid && req_ready;

        RW0_en     = fire;
        RW0_wmode  = fire && req_write;
        RW0_addr   = req_addr;
        RW0_wdata  = req_wdata;

        busy       = !reset && (inflight_q || !fifo_empty);
    end

    // Next-state for the in-flight flag, FIFO occupancy and circular pointers.
    always_comb begin
        inflight_d = fire && !req_write;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset; discards any pending reads.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Response storage: captures bank read data at the tail.
    always_ff @(posedge clock) begin
        // NOTE: the data array has no reset; count_q gates every read, so stale contents are never observed.
        if (push) begin
            mem_q[wr_ptr_q] <= RW0_rdata;
        end
    end

    // The credit rule must make a push into a full FIFO impossible.
    a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        !(push && !fifo_pop && (count_q == FULL_C)));

endmodule

// File: tb/tb_cc_banks_rw0_initiator.sv
// Self-checking bench for cc_banks_rw0_initiator.
// A behavioural RW0 bank sits on the bank side. A shadow memory plus an
// expected-response queue form the scoreboard: read fires push expected data,
// and a negedge monitor pops and compares whenever a response is taken.
module tb_cc_banks_rw0_initiator;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 64;
    localparam int RSP_DEPTH = 2;
    localparam int NWORDS    = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q [$];

    // Bank model storage and the scoreboard's independent shadow copy.
    logic [DATA_W-1:0] bank_w   [NWORDS];
    bit                bank_wr  [NWORDS];
    logic [DATA_W-1:0] shadow_w [NWORDS];
    bit                shadow_wr[NWORDS];

    cc_banks_rw0_initiator #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .RW0_addr (RW0_addr),
        .RW0_en   (RW0_en),
        .RW0_wmode(RW0_wmode),
        .RW0_wdata(RW0_wdata),
        .RW0_rdata(RW0_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Preload pattern; word 0x0005 holds 0xA5A5...
    function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] a);
        if (a == 13'h0005) return 64'hA5A5_A5A5_A5A5_A5A5;
        return {16'hC0DE, 3'b000, a, 16'h5A5A, 3'b000, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Behavioural single-port bank: 1-cycle read latency.
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                bank_w[RW0_addr]  <= RW0_wdata;
                bank_wr[RW0_addr] <= 1'b1;
            end else begin
                RW0_rdata <= bank_wr[RW0_addr] ? bank_w[RW0_addr] : preload(RW0_addr);
            end
        end
    end

    // Monitor: reset-time strobe check, response compare, expected-data capture.
    always @(negedge clock) begin
        if (reset) begin
            check("rw0_en_in_reset", 64'(RW0_en), 64'd0);
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got %h expected no response at %0t", rsp_rdata, $time);
            end else begin
                check("rsp_data", rsp_rdata, exp_q.pop_front());
            end
        end
        if (req_valid && req_ready) begin
            if (req_write) begin
                shadow_w[req_addr]  <= req_wdata;
                shadow_wr[req_addr] <= 1'b1;
            end else begin
                exp_q.push_back(shadow_wr[req_addr] ? shadow_w[req_addr] : preload(req_addr));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name);
        step();
    endtask

    initial begin
        int acc;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 13'h0005;
        req_wdata = 64'hDEAD_BEEF_0000_0001;
        rsp_ready = 1'b1;

        // ---- 1: reset state, then a single read of 0x0005 ----
        step();
        step();
        @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_wmode",     64'(RW0_wmode), 64'd0);
        step();
        reset     = 1'b0;
        req_write = 1'b0;
        req_addr  = 13'h0005;
        @(negedge clock);
        check("t1_rw0_en",    64'(RW0_en),    64'd1);
        check("t1_req_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        @(negedge clock);
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_rsp_data",  rsp_rdata,      64'hA5A5_A5A5_A5A5_A5A5);
        check("t1_busy_n1",   64'(busy),      64'd1);
        step();
        @(negedge clock);
        check("t1_busy_n2",   64'(busy),      64'd0);
        check("t1_rsp_idle",  64'(rsp_valid), 64'd0);
        step();

        // ---- 2: 8 back-to-back reads across 0x0800 ----
        for (int i = 0; i <= 8; i++) begin
            req_valid = (i < 8);
            req_write = 1'b0;
            req_addr  = 13'h07FC + 13'(i);
            @(negedge clock);
            if (i < 8) check("t2_req_ready", 64'(req_ready), 64'd1);
            if (i > 0) begin
                check("t2_rsp_valid", 64'(rsp_valid), 64'd1);
                check("t2_rsp_order", rsp_rdata, preload(13'h07FC + 13'(i - 1)));
            end
            step();
        end
        req_valid = 1'b0;
        wait_idle("t2_idle");

        // ---- 3: rsp_ready=0, offer 4 reads; only 2 fit ----
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 13'h0100 + 13'(acc);
            @(negedge clock);
            if (req_ready) acc++;
            step();
        end
        check("t3_accepted", 64'(acc), 64'd2);
        @(negedge clock);
        check("t3_stalled", 64'(req_ready), 64'd0);
        step();

        // ---- 4: write during the stall is accepted immediately ----
        req_write = 1'b1;
        req_addr  = 13'h1FFF;
        req_wdata = 64'h0000_0000_0000_1234;
        @(negedge clock);
        check("t4_wr_ready", 64'(req_ready), 64'd1);
        check("t4_wr_en",    64'(RW0_en),    64'd1);
        check("t4_wr_wmode", 64'(RW0_wmode), 64'd1);
        step();
        req_write = 1'b0;
        req_addr  = 13'h0100 + 13'(acc);
        @(negedge clock);
        check("t4_still_stalled", 64'(req_ready), 64'd0);
        check("t4_head",          rsp_rdata,      preload(13'h0100));
        step();

        // Release backpressure; the remaining reads go in as credit frees.
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_valid = (acc < 4);
            req_write = 1'b0;
            req_addr  = 13'h0100 + 13'(acc);
            @(negedge clock);
            if (req_valid && req_ready) acc++;
            step();
        end
        check("t3_all_accepted", 64'(acc), 64'd4);
        req_valid = 1'b0;
        wait_idle("t3_idle");

        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 13'h1FFF;
        step();
        req_valid = 1'b0;
        @(negedge clock);
        check("t4_rd_valid", 64'(rsp_valid), 64'd1);
        check("t4_rd_data",  rsp_rdata,      64'h0000_0000_0000_1234);
        step();
        wait_idle("t4_idle");

        // ---- 5: reset right after a read fires discards it ----
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 13'h0020;
        @(negedge clock);
        check("t5_fire", 64'(RW0_en), 64'd1);
        step();
        req_valid = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        @(negedge clock);
        check("t5_no_rsp_a", 64'(rsp_valid), 64'd0);
        check("t5_busy_a",   64'(busy),      64'd0);
        step();
        @(negedge clock);
        check("t5_no_rsp_b", 64'(rsp_valid), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check("t5_ready_after", 64'(req_ready), 64'd1);
        check("t5_no_rsp_c",    64'(rsp_valid), 64'd0);
        check("t5_busy_after",  64'(busy),      64'd0);
        step();

        // ---- 6: random traffic with random backpressure and rare resets ----
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = ($urandom_range(0, 2) == 0);
            req_addr  = 13'h1FF0 + 13'($urandom_range(0, 15));
            req_wdata = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                exp_q.delete();
            end else begin
                reset = 1'b0;
            end
            step();
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("t6_drain");
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
